// File: rtl/exc_flush_ctrl.sv
// Stall arbitration, exception flush/redirect and post-flush mask window.
// Optional accepted-exception counter enabled by defining EXC_FLUSH_STATS_EN.
module exc_flush_ctrl #(
  parameter logic [31:0] EXC_HANDLER_ADDR = 32'h00000020,
  parameter int          MASK_CYCLES      = 1,
  parameter int          STALL_TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] exc_type_o,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        exc_busy_o,
  output logic        stall_timeout_o,
  output logic [15:0] exc_count_o
);

  localparam logic [31:0] EXC_ERET  = 32'h0000000e;
  localparam logic [3:0]  MASK_INIT = 4'(MASK_CYCLES);
  localparam logic [15:0] WD_LIMIT  = 16'(STALL_TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MASK = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  mask_cnt_q, mask_cnt_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
  logic        accept_s;
  logic [5:0]  stall_req_s;

  // Stall arbitration: EX stalls freeze one more stage than ID and win.
  always_comb begin
    stall_req_s = 6'b000000;
    if (stallreq_ex_i) begin
      stall_req_s = 6'b001111;
    end else if (stallreq_id_i) begin
      stall_req_s = 6'b000111;
    end else begin
      stall_req_s = 6'b000000;
    end
  end

  // FSM next state and all combinational outputs; reset gates every output.
  always_comb begin
    state_d    = state_q;
    mask_cnt_d = mask_cnt_q;
    accept_s   = 1'b0;
    stall_o    = 6'b000000;
    flush_o    = 1'b0;
    new_pc_o   = 32'h00000000;
    exc_type_o = 32'h00000000;
    exc_busy_o = 1'b0;
    if (rst) begin
      state_d    = S_IDLE;
      mask_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (exception_type_i != 32'h00000000) begin
            // Flush wins over any stall: the stalling instruction is squashed.
            accept_s   = 1'b1;
            flush_o    = 1'b1;
            exc_type_o = exception_type_i;
            new_pc_o   = (exception_type_i == EXC_ERET) ? cp0_epc_i : EXC_HANDLER_ADDR;
            state_d    = S_MASK;
            mask_cnt_d = MASK_INIT;
          end else begin
            stall_o = stall_req_s;
          end
        end
        S_MASK: begin
          exc_busy_o = 1'b1;
          stall_o    = stall_req_s;
          if (mask_cnt_q <= 4'd1) begin
            state_d    = S_IDLE;
            mask_cnt_d = 4'd0;
          end else begin
            mask_cnt_d = mask_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d    = S_IDLE;
          mask_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Watchdog: saturating run length of stalled cycles, flag latches one cycle later.
  always_comb begin
    timeout_d = timeout_q | (wd_cnt_q == WD_LIMIT);
    if (stall_o == 6'b000000) begin
      wd_cnt_d = 16'd0;
    end else if (wd_cnt_q >= WD_LIMIT) begin
      wd_cnt_d = WD_LIMIT;
    end else begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  // State, mask counter and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_cnt_q <= 4'd0;
      wd_cnt_q   <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_cnt_q <= mask_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign stall_timeout_o = timeout_q & ~rst;

`ifdef EXC_FLUSH_STATS_EN
  logic [15:0] exc_cnt_q;

  // Saturating count of accepted exceptions, eret included.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_cnt_q <= 16'h0000;
    end else if (accept_s && (exc_cnt_q != 16'hFFFF)) begin
      exc_cnt_q <= exc_cnt_q + 16'h0001;
    end else begin
      exc_cnt_q <= exc_cnt_q;
    end
  end

  assign exc_count_o = rst ? 16'h0000 : exc_cnt_q;
`else
  assign exc_count_o = 16'h0000;
`endif

endmodule
